mem_burst_engine: RTL

Memory-side burst adapter between the 4-way set-associative cache controller and the 32-bit main-memory port. Accepts one block-level request (512-bit writeback or 512-bit line fill) from the controller and serialises it into 16 word beats with a valid/ready handshake. On a fill it assembles the returned words into a full block. It pulses completion back to the controller's EVICT/ALLOCATE states.

---
 rtl/cache_pkg.sv | 34 +++
 rtl/mem_burst_engine_if.sv | 29 ++
 rtl/mem_burst_engine.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller and its memory-side burst engine.
// Holds the word/block geometry, the memory-facing state encoding and a helper
// that selects one word out of a block.
package cache_pkg;

    localparam int WORD_SIZE        = 32;
    localparam int BLOCK_OFFSET     = 4;
    localparam int WORDS_PER_BLOCK  = 1 << BLOCK_OFFSET;
    localparam int BLOCK_DATA_WIDTH = WORD_SIZE << BLOCK_OFFSET;

    // Encoding is shared with the cache controller's memory-facing states.
    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_WRITE = 2'd1;
    localparam logic [1:0] STATE_READ  = 2'd2;
    localparam logic [1:0] STATE_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = STATE_IDLE,
        WRITE = STATE_WRITE,
        READ  = STATE_READ,
        DONE  = STATE_DONE
    } state_t;

    typedef logic [BLOCK_OFFSET-1:0] beat_cnt_t;

    // Word i of a block lives at bits [32*i+31 : 32*i].
    function automatic logic [WORD_SIZE-1:0] block_word(
        input logic [BLOCK_DATA_WIDTH-1:0] blk,
        input beat_cnt_t                   idx
    );
        return blk[WORD_SIZE*idx +: WORD_SIZE];
    endfunction

endpackage

// File: rtl/mem_burst_engine_if.sv
// Word-wide main-memory port with a valid/ready handshake.
//   mem_addr   word address of the current beat
//   mem_wdata  write data of the current beat
//   mem_rw     1 = write beat, 0 = read beat
//   mem_valid  beat request valid
//   mem_ready  memory accepts (write) or returns (read) the beat
//   mem_rdata  read data, valid in the cycle the beat completes
// master: the burst engine; slave: the memory.
interface mem_burst_engine_if;
    import cache_pkg::*;

    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_rw;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_rw, mem_valid,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rw, mem_valid,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_burst_engine.sv
// Memory-side burst adapter for the set-associative cache controller.
// Takes one block request (writeback or line fill) and serialises it into
// WORDS_PER_BLOCK word beats on the memory port, ascending from the block base.
// Fill data is assembled into ctl_res_rdata; completion is a one-cycle pulse.
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   ctl_req_enable     request strobe, only looked at in IDLE
//   ctl_req_rw         1 = writeback, 0 = line fill
//   ctl_req_addr       word address, low BLOCK_OFFSET bits ignored
//   ctl_req_wdata      block to write back
//   ctl_res_rdata      assembled fill block (held until the next fill)
//   ctl_res_ready      one-cycle completion pulse
//   ctl_busy           high whenever not IDLE
//   mem                memory port (master side)
// All outputs are registered.
module mem_burst_engine
    import cache_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ctl_req_enable,
    input  logic                        ctl_req_rw,
    input  logic [WORD_SIZE-1:0]        ctl_req_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] ctl_req_wdata,
    output logic [BLOCK_DATA_WIDTH-1:0] ctl_res_rdata,
    output logic                        ctl_res_ready,
    output logic                        ctl_busy,
    mem_burst_engine_if.master          mem
);

    localparam int TAG_W = WORD_SIZE - BLOCK_OFFSET;

    state_t                      state, state_n;
    beat_cnt_t                   cnt, cnt_n, cnt_inc;
    logic [TAG_W-1:0]            base_tag, base_tag_n;
    logic [BLOCK_DATA_WIDTH-1:0] wbuf, wbuf_n;
    logic [BLOCK_DATA_WIDTH-1:0] rdata_n;
    logic [WORD_SIZE-1:0]        addr_n, wdata_n;
    logic                        valid_n, rw_n, ready_n, busy_n;
    logic                        fire;

    // Block alignment makes the word-offset bits of the request irrelevant.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ctl_req_addr[BLOCK_OFFSET-1:0];

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        base_tag_n = base_tag;
        wbuf_n     = wbuf;
        rdata_n    = ctl_res_rdata;
        addr_n     = mem.mem_addr;
        wdata_n    = mem.mem_wdata;
        rw_n       = mem.mem_rw;
        valid_n    = mem.mem_valid;
        ready_n    = 1'b0;
        busy_n     = ctl_busy;
        cnt_inc    = cnt + 1'b1;
        fire       = mem.mem_valid && mem.mem_ready;

        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (ctl_req_enable) begin
                    state_n    = ctl_req_rw ? WRITE : READ;
                    cnt_n      = '0;
                    base_tag_n = ctl_req_addr[WORD_SIZE-1:BLOCK_OFFSET];
                    wbuf_n     = ctl_req_wdata;
                    addr_n     = {ctl_req_addr[WORD_SIZE-1:BLOCK_OFFSET], {BLOCK_OFFSET{1'b0}}};
                    wdata_n    = ctl_req_rw ? block_word(ctl_req_wdata, '0) : '0;
                    rw_n       = ctl_req_rw;
                    valid_n    = 1'b1;
                    busy_n     = 1'b1;
                end
            end
            WRITE, READ: begin
                // Address/data/rw only advance on a completed beat, so they hold
                // through memory stalls.
                if (fire) begin
                    if (state == READ) begin
                        rdata_n[WORD_SIZE*cnt +: WORD_SIZE] = mem.mem_rdata;
                    end
                    if (cnt == beat_cnt_t'(WORDS_PER_BLOCK - 1)) begin
                        state_n = DONE;
                        cnt_n   = '0;
                        valid_n = 1'b0;
                        ready_n = 1'b1;
                    end else begin
                        cnt_n   = cnt_inc;
                        // Aligned base: beat index fills the offset bits, no carry.
                        addr_n  = {base_tag, cnt_inc};
                        wdata_n = (state == WRITE) ? block_word(wbuf, cnt_inc) : '0;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            ctl_res_rdata  <= '0;
            ctl_res_ready  <= 1'b0;
            ctl_busy       <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            mem.mem_rw     <= 1'b0;
            mem.mem_valid  <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            ctl_res_rdata  <= rdata_n;
            ctl_res_ready  <= ready_n;
            ctl_busy       <= busy_n;
            mem.mem_addr   <= addr_n;
            mem.mem_wdata  <= wdata_n;
            mem.mem_rw     <= rw_n;
            mem.mem_valid  <= valid_n;
        end
    end

    // Request latches are only read after being loaded in IDLE.
    always_ff @(posedge clk) begin
        base_tag <= base_tag_n;
        wbuf     <= wbuf_n;
    end

endmodule
